// File: rtl/hls_run_ctrl_pkg.sv
// Shared types and constants for the HLS run controller.
// Timeout support is enabled by HLS_RUN_CTRL_TIMEOUT_EN.
package hls_run_ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    LOAD_WAIT,
    START,
    RUN,
    READ,
    READ_WAIT,
    OUT,
    DONE
  } state_t;

  localparam logic [7:0] BYTE_SIZE = 8'd8;
  localparam logic [1:0] LANE0     = 2'b01;

endpackage

// File: rtl/hls_cycle_counter.sv
// Saturating 32-bit cycle counter with clear and enable.
// Clear has priority over enable.
module hls_cycle_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  output logic [31:0] count
);

  always_ff @(posedge clock) begin
    if (reset || clear)
      count <= '0;
    else if (enable && count != 32'hFFFF_FFFF)
      count <= count + 32'd1;
  end

endmodule

// File: rtl/hls_run_ctrl.sv
// Load / start / readback sequencer around an HLS slave memory.
// Define HLS_RUN_CTRL_TIMEOUT_EN to abort RUN after TIMEOUT_CYCLES.
module hls_run_ctrl
  import hls_run_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 14,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 200000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W-1:0] cfg_load_len,
  input  logic [ADDR_W-1:0] cfg_read_len,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [1:0]        S_oe_ram,
  output logic [1:0]        S_we_ram,
  output logic [ADDR_W-1:0] S_addr_ram,
  output logic [DATA_W-1:0] S_Wdata_ram,
  output logic [7:0]        S_data_ram_size,
  input  logic [DATA_W-1:0] Sout_Rdata_ram,
  input  logic [1:0]        Sout_DataRdy,
  output logic              start_port,
  input  logic              done_port,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [31:0]       cycles,
  output logic              timeout
);

  localparam logic [31:0] TO_LIM = 32'(TIMEOUT_CYCLES);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base, load_len, read_len;
  logic [ADDR_W-1:0] idx, idx_inc, addr;
  logic [7:0]        rbyte;
  logic              timeout_q, rdy, to_hit;
  logic              cnt_clr, cnt_en;
  logic              unused_in;

  assign idx_inc = idx + ADDR_W'(1);
  assign addr    = base + idx;
  assign rdy     = Sout_DataRdy[0];
  assign unused_in = ^{Sout_Rdata_ram[DATA_W-1:8], Sout_DataRdy[1]};

`ifdef HLS_RUN_CTRL_TIMEOUT_EN
  // A done in the limit cycle wins over the timeout.
  assign to_hit = (state == RUN) && !done_port && (cycles == TO_LIM);
`else
  logic unused_lim;
  assign unused_lim = ^TO_LIM;
  assign to_hit     = 1'b0;
`endif

  assign cnt_clr = (state == IDLE) && go;
  assign cnt_en  = (state == START) || ((state == RUN) && !to_hit);

  hls_cycle_counter u_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .count  (cycles)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (go)
          state_nx = (cfg_load_len == '0) ? START : LOAD;
      LOAD:
        if (in_valid) state_nx = LOAD_WAIT;
      LOAD_WAIT:
        if (rdy)
          state_nx = (idx_inc == load_len) ? START : LOAD;
      START:
        state_nx = RUN;
      RUN:
        if (done_port)
          state_nx = (read_len == '0) ? DONE : READ;
        else if (to_hit)
          state_nx = DONE;
      READ:
        state_nx = READ_WAIT;
      READ_WAIT:
        if (rdy) state_nx = OUT;
      OUT:
        if (out_ready)
          state_nx = (idx_inc == read_len) ? DONE : READ;
      DONE:
        state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      base      <= '0;
      load_len  <= '0;
      read_len  <= '0;
      idx       <= '0;
      rbyte     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE && go) begin
        base      <= cfg_base_addr;
        load_len  <= cfg_load_len;
        read_len  <= cfg_read_len;
        idx       <= '0;
        timeout_q <= 1'b0;
      end
      if (state == LOAD_WAIT && rdy)
        idx <= (idx_inc == load_len) ? '0 : idx_inc;
      if (to_hit)
        timeout_q <= 1'b1;
      if (state == READ_WAIT && rdy)
        rbyte <= Sout_Rdata_ram[7:0];
      if (state == OUT && out_ready)
        idx <= idx_inc;
    end
  end

  always_comb begin
    in_ready        = 1'b0;
    S_oe_ram        = 2'b00;
    S_we_ram        = 2'b00;
    S_addr_ram      = '0;
    S_Wdata_ram     = '0;
    S_data_ram_size = 8'd0;
    start_port      = 1'b0;
    out_valid       = 1'b0;
    out_data        = 8'd0;
    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          S_we_ram        = LANE0;
          S_addr_ram      = addr;
          S_Wdata_ram     = {{(DATA_W-8){1'b0}}, in_data};
          S_data_ram_size = BYTE_SIZE;
        end
      end
      START:
        start_port = 1'b1;
      READ: begin
        S_oe_ram        = LANE0;
        S_addr_ram      = addr;
        S_data_ram_size = BYTE_SIZE;
      end
      OUT: begin
        out_valid = 1'b1;
        out_data  = rbyte;
      end
      default: ;
    endcase
  end

  assign busy    = (state != IDLE);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_hls_run_ctrl.sv
// Directed self-checking bench for hls_run_ctrl.
// Build with HLS_RUN_CTRL_TIMEOUT_EN to exercise the timeout path.
module tb_hls_run_ctrl;

  localparam int AW = 14;
  localparam int DW = 16;

  logic          clock, reset, go;
  logic [AW-1:0] cfg_base_addr, cfg_load_len, cfg_read_len;
  logic          in_valid, in_ready;
  logic [7:0]    in_data;
  logic [1:0]    S_oe_ram, S_we_ram;
  logic [AW-1:0] S_addr_ram;
  logic [DW-1:0] S_Wdata_ram, Sout_Rdata_ram;
  logic [7:0]    S_data_ram_size;
  logic [1:0]    Sout_DataRdy;
  logic          start_port, done_port;
  logic          out_valid, out_ready;
  logic [7:0]    out_data;
  logic          busy, timeout;
  logic [31:0]   cycles;

  int n_cmp = 0;
  int n_err = 0;
  int tmo   = 0;

  hls_run_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(50)
  ) dut (
    .clock(clock), .reset(reset), .go(go),
    .cfg_base_addr(cfg_base_addr),
    .cfg_load_len(cfg_load_len),
    .cfg_read_len(cfg_read_len),
    .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram),
    .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram),
    .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram),
    .Sout_DataRdy(Sout_DataRdy),
    .start_port(start_port), .done_port(done_port),
    .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready),
    .busy(busy), .cycles(cycles), .timeout(timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave memory model: answers any strobe one cycle later.
  logic [7:0]    mem [0:(1<<AW)-1];
  logic [AW-1:0] wr_addr [0:31];
  logic [DW-1:0] wr_data [0:31];
  logic [7:0]    wr_size [0:31];
  int wr_n = 0, rd_n = 0, start_n = 0;

  initial Sout_DataRdy = 2'b00;
  initial Sout_Rdata_ram = '0;

  always @(posedge clock) begin
    Sout_DataRdy   <= {1'b0, S_we_ram[0] | S_oe_ram[0]};
    Sout_Rdata_ram <= {8'h00, mem[S_addr_ram]};
    if (S_we_ram[0]) begin
      mem[S_addr_ram] <= S_Wdata_ram[7:0];
      if (wr_n < 32) begin
        wr_addr[wr_n] <= S_addr_ram;
        wr_data[wr_n] <= S_Wdata_ram;
        wr_size[wr_n] <= S_data_ram_size;
      end
      wr_n <= wr_n + 1;
    end
    if (S_oe_ram[0]) rd_n <= rd_n + 1;
    if (start_port) start_n <= start_n + 1;
  end

  task automatic start_go(input logic [AW-1:0] b,
                          input logic [AW-1:0] ll,
                          input logic [AW-1:0] rl);
    cfg_base_addr = b;
    cfg_load_len  = ll;
    cfg_read_len  = rl;
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
  endtask

  task automatic feed_byte(input logic [7:0] b);
    int k;
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    while (!in_ready && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (!in_ready) tmo++;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_start();
    int k;
    k = 0;
    while (!start_port && k < 40) begin
      @(negedge clock);
      k++;
    end
    if (!start_port) tmo++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({busy, in_ready, start_port, out_valid, timeout,
         S_we_ram, S_oe_ram} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_ctl got=%b want=0",
        {busy, in_ready, start_port, out_valid, timeout,
         S_we_ram, S_oe_ram});
    end
    n_cmp++;
    if (cycles !== 32'd0) begin
      n_err++;
      $display("FAIL reset_cycles got=%0d want=0", cycles);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_load();
    int w0, s0;
    logic [7:0] b;
    w0 = wr_n;
    s0 = start_n;
    start_go(14'h100, 14'd4, 14'd3);
    for (int i = 0; i < 4; i++) begin
      b = 8'(8'h11 * (i + 1));
      feed_byte(b);
    end
    wait_start();
    n_cmp++;
    if (wr_n - w0 !== 4) begin
      n_err++;
      $display("FAIL load_count got=%0d want=4", wr_n - w0);
    end
    for (int i = 0; i < 4; i++) begin
      b = 8'(8'h11 * (i + 1));
      n_cmp++;
      if (wr_addr[w0+i] !== AW'(14'h100 + i)) begin
        n_err++;
        $display("FAIL load_addr%0d got=%h want=%h",
          i, wr_addr[w0+i], 14'h100 + i);
      end
      n_cmp++;
      if ({wr_size[w0+i], wr_data[w0+i]} !== {8'd8, 8'h00, b}) begin
        n_err++;
        $display("FAIL load_data%0d got=%h/%h want=8/%h",
          i, wr_size[w0+i], wr_data[w0+i], b);
      end
    end
    n_cmp++;
    if (start_n - s0 !== 0) begin
      n_err++;
      $display("FAIL start_early got=%0d want=0", start_n - s0);
    end
  endtask

  task automatic test_run();
    int s0;
    s0 = start_n;
    @(negedge clock);
    n_cmp++;
    if ({start_port, cycles} !== {1'b0, 32'd1}) begin
      n_err++;
      $display("FAIL run1 got=%b/%0d want=0/1", start_port, cycles);
    end
    repeat (6) @(negedge clock);
    done_port = 1'b1;
    @(negedge clock);
    done_port = 1'b0;
    n_cmp++;
    if (cycles !== 32'd8) begin
      n_err++;
      $display("FAIL run_cycles got=%0d want=8", cycles);
    end
    n_cmp++;
    if ({S_oe_ram, S_addr_ram, S_data_ram_size} !==
        {2'b01, 14'h100, 8'd8}) begin
      n_err++;
      $display("FAIL done_to_read got=%b/%h/%0d want=01/100/8",
        S_oe_ram, S_addr_ram, S_data_ram_size);
    end
    n_cmp++;
    if (start_n - s0 !== 1) begin
      n_err++;
      $display("FAIL start_pulses got=%0d want=1", start_n - s0);
    end
  endtask

  task automatic test_readback();
    logic [7:0] got [0:3];
    logic [7:0] held_val;
    logic       held;
    int n, k;
    n = 0;
    k = 0;
    held = 1'b0;
    held_val = 8'h00;
    out_ready = 1'b0;
    while (busy && k < 60) begin
      out_ready = ~out_ready;
      if (out_valid) begin
        if (held) begin
          n_cmp++;
          if (out_data !== held_val) begin
            n_err++;
            $display("FAIL stall_stable got=%h want=%h",
              out_data, held_val);
          end
        end
        if (out_ready) begin
          if (n < 4) got[n] = out_data;
          n++;
          held = 1'b0;
        end else begin
          held = 1'b1;
          held_val = out_data;
        end
      end
      @(negedge clock);
      k++;
    end
    out_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || n != 3) begin
      n_err++;
      $display("FAIL read_count got=%0d busy=%b want=3 busy=0",
        n, busy);
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (n > i && got[i] !== 8'(8'h11 * (i + 1))) begin
        n_err++;
        $display("FAIL read_byte%0d got=%h want=%h",
          i, got[i], 8'(8'h11 * (i + 1)));
      end
    end
    n_cmp++;
    if (cycles !== 32'd8) begin
      n_err++;
      $display("FAIL cycles_hold got=%0d want=8", cycles);
    end
  endtask

  task automatic test_zero_len();
    int r0;
    r0 = rd_n;
    start_go(14'h050, 14'd0, 14'd0);
    n_cmp++;
    if (start_port !== 1'b1) begin
      n_err++;
      $display("FAIL go_to_start got=%b want=1", start_port);
    end
    @(negedge clock);
    done_port = 1'b1;
    @(negedge clock);
    done_port = 1'b0;
    n_cmp++;
    if ({busy, S_oe_ram, cycles} !== {1'b1, 2'b00, 32'd2}) begin
      n_err++;
      $display("FAIL done_state got=%b/%b/%0d want=1/00/2",
        busy, S_oe_ram, cycles);
    end
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || rd_n != r0) begin
      n_err++;
      $display("FAIL zero_idle got=%b/%0d want=0/0",
        busy, rd_n - r0);
    end
  endtask

  task automatic test_timeout();
    int r0, k;
    r0 = rd_n;
    k = 0;
    start_go(14'h000, 14'd0, 14'd1);
`ifdef HLS_RUN_CTRL_TIMEOUT_EN
    while (busy && k < 200) begin
      @(negedge clock);
      k++;
    end
    n_cmp++;
    if ({busy, timeout, cycles} !== {1'b0, 1'b1, 32'd50}) begin
      n_err++;
      $display("FAIL timeout got=%b/%b/%0d want=0/1/50",
        busy, timeout, cycles);
    end
    n_cmp++;
    if (rd_n != r0) begin
      n_err++;
      $display("FAIL timeout_noread got=%0d want=0", rd_n - r0);
    end
`else
    repeat (200) @(negedge clock);
    n_cmp++;
    if ({busy, timeout, cycles} !== {1'b1, 1'b0, 32'd200}) begin
      n_err++;
      $display("FAIL run_hang got=%b/%b/%0d want=1/0/200",
        busy, timeout, cycles);
    end
    n_cmp++;
    if (rd_n != r0) begin
      n_err++;
      $display("FAIL hang_noread got=%0d want=0", rd_n - r0);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_cmp++;
    if ({busy, cycles} !== {1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL hang_reset got=%b/%0d want=0/0", busy, cycles);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int w0, k, n;
    logic [7:0] got [0:1];
    start_go(14'h200, 14'd4, 14'd0);
    feed_byte(8'h77);
    w0 = wr_n;
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h99;
    @(negedge clock);
    n_cmp++;
    if ({busy, in_ready, start_port, out_valid, timeout,
         S_we_ram, S_oe_ram, S_addr_ram, S_Wdata_ram,
         S_data_ram_size, out_data, cycles} !== '0) begin
      n_err++;
      $display("FAIL midreset_outs busy=%b rdy=%b we=%b cyc=%0d want=0",
        busy, in_ready, S_we_ram, cycles);
    end
    @(negedge clock);
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (wr_n != w0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_quiet got=%0d/%b want=0/0",
        wr_n - w0, busy);
    end
    w0 = wr_n;
    start_go(14'h3FFF, 14'd2, 14'd2);
    feed_byte(8'hA5);
    feed_byte(8'h5A);
    wait_start();
    n_cmp++;
    if (wr_n - w0 != 2 || wr_addr[w0] !== 14'h3FFF ||
        wr_addr[w0+1] !== 14'h0000) begin
      n_err++;
      $display("FAIL wrap_addr got=%h,%h want=3fff,0000",
        wr_addr[w0], wr_addr[w0+1]);
    end
    @(negedge clock);
    done_port = 1'b1;
    @(negedge clock);
    done_port = 1'b0;
    n_cmp++;
    if (cycles !== 32'd2) begin
      n_err++;
      $display("FAIL clean_cycles got=%0d want=2", cycles);
    end
    out_ready = 1'b1;
    n = 0;
    k = 0;
    while (busy && k < 40) begin
      if (out_valid && n < 2) begin
        got[n] = out_data;
        n++;
      end
      @(negedge clock);
      k++;
    end
    out_ready = 1'b0;
    n_cmp++;
    if (n != 2 || got[0] !== 8'hA5 || got[1] !== 8'h5A) begin
      n_err++;
      $display("FAIL clean_read got=%0d:%h,%h want=2:a5,5a",
        n, got[0], got[1]);
    end
  endtask

  task automatic test_bounds();
    n_cmp++;
    if (tmo != 0) begin
      n_err++;
      $display("FAIL wait_bound got=%0d want=0", tmo);
    end
  endtask

  initial begin
    go = 1'b0;
    cfg_base_addr = '0;
    cfg_load_len = '0;
    cfg_read_len = '0;
    in_valid = 1'b0;
    in_data = 8'h00;
    done_port = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    test_reset();
    test_load();
    test_run();
    test_readback();
    test_zero_len();
    test_timeout();
    test_reset_mid();
    test_bounds();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_err);
    $finish;
  end

endmodule
